cdb_arbiter: RTL

//   Single-bus scheduler for the common data bus (CDB). The RS ALU and the LSB each produce
//   one result per cycle as {ROB_pos, val}; this block buffers them in per-source FIFOs and

---
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and LSB results in small per-source FIFOs
// and broadcasts one result per cycle on a registered bus, round-robin on ties.
module cdb_arbiter #(
  parameter int ROB_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob_pos,
  input  logic [DATA_W-1:0] alu_val,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [ROB_W-1:0]  lsb_rob_pos,
  input  logic [DATA_W-1:0] lsb_val,
  output logic              lsb_ready,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_rob_pos,
  output logic [DATA_W-1:0] cdb_val,
  output logic              cdb_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ROB_W-1:0]  r_alu_rob [DEPTH];
  logic [DATA_W-1:0] r_alu_val [DEPTH];
  logic [ROB_W-1:0]  r_lsb_rob [DEPTH];
  logic [DATA_W-1:0] r_lsb_val [DEPTH];
  logic [PW-1:0]     r_alu_wp, r_alu_rp, r_lsb_wp, r_lsb_rp;
  logic [CW-1:0]     r_alu_cnt, r_lsb_cnt;
  logic              r_rr_last;
  logic              r_cdb_valid;
  logic [ROB_W-1:0]  r_cdb_rob_pos;
  logic [DATA_W-1:0] r_cdb_val;
  logic              r_cdb_src;

  logic w_act;
  logic w_alu_ne, w_lsb_ne;
  logic w_alu_push, w_lsb_push;
  logic w_alu_pop, w_lsb_pop;

  assign w_act     = rdy & ~clear;
  assign w_alu_ne  = (r_alu_cnt != '0);
  assign w_lsb_ne  = (r_lsb_cnt != '0);

  // Ready looks only at the current count, so a same-cycle pop never opens a slot.
  assign alu_ready = rdy & (r_alu_cnt < FULL);
  assign lsb_ready = rdy & (r_lsb_cnt < FULL);

  assign w_alu_push = w_act & alu_valid & alu_ready;
  assign w_lsb_push = w_act & lsb_valid & lsb_ready;

  // r_rr_last holds the source granted on the last tie; the other side wins the next one.
  assign w_alu_pop  = w_act & w_alu_ne & (~w_lsb_ne | r_rr_last);
  assign w_lsb_pop  = w_act & w_lsb_ne & ~w_alu_pop;

  assign cdb_valid   = r_cdb_valid;
  assign cdb_rob_pos = r_cdb_rob_pos;
  assign cdb_val     = r_cdb_val;
  assign cdb_src     = r_cdb_src;

  always_ff @(posedge clk) begin
    if (w_alu_push) begin
      r_alu_rob[r_alu_wp] <= alu_rob_pos;
      r_alu_val[r_alu_wp] <= alu_val;
    end
    if (w_lsb_push) begin
      r_lsb_rob[r_lsb_wp] <= lsb_rob_pos;
      r_lsb_val[r_lsb_wp] <= lsb_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_wp      <= '0;
      r_alu_rp      <= '0;
      r_alu_cnt     <= '0;
      r_lsb_wp      <= '0;
      r_lsb_rp      <= '0;
      r_lsb_cnt     <= '0;
      r_rr_last     <= 1'b1;
      r_cdb_valid   <= 1'b0;
      r_cdb_rob_pos <= '0;
      r_cdb_val     <= '0;
      r_cdb_src     <= 1'b0;
    end else if (rdy) begin
      if (clear) begin
        r_alu_wp    <= '0;
        r_alu_rp    <= '0;
        r_alu_cnt   <= '0;
        r_lsb_wp    <= '0;
        r_lsb_rp    <= '0;
        r_lsb_cnt   <= '0;
        r_rr_last   <= 1'b1;
        r_cdb_valid <= 1'b0;
      end else begin
        if (w_alu_push) r_alu_wp <= r_alu_wp + PW'(1);
        if (w_alu_pop)  r_alu_rp <= r_alu_rp + PW'(1);
        if (w_lsb_push) r_lsb_wp <= r_lsb_wp + PW'(1);
        if (w_lsb_pop)  r_lsb_rp <= r_lsb_rp + PW'(1);
        r_alu_cnt <= r_alu_cnt + CW'(w_alu_push) - CW'(w_alu_pop);
        r_lsb_cnt <= r_lsb_cnt + CW'(w_lsb_push) - CW'(w_lsb_pop);

        if (w_alu_pop) begin
          r_cdb_valid   <= 1'b1;
          r_cdb_rob_pos <= r_alu_rob[r_alu_rp];
          r_cdb_val     <= r_alu_val[r_alu_rp];
          r_cdb_src     <= 1'b0;
        end else if (w_lsb_pop) begin
          r_cdb_valid   <= 1'b1;
          r_cdb_rob_pos <= r_lsb_rob[r_lsb_rp];
          r_cdb_val     <= r_lsb_val[r_lsb_rp];
          r_cdb_src     <= 1'b1;
        end else begin
          r_cdb_valid   <= 1'b0;
        end

        if (w_alu_ne && w_lsb_ne) r_rr_last <= w_lsb_pop;
      end
    end
  end

endmodule
